maze_move_ctrl: RTL and testbench
=================================

Name: maze_move_ctrl

Overview:
- Sequences player movement for the maze game.
- Turns debounced direction buttons into validated moves, checks the target cell against the maze wall memory, and commits the new `player_pos` to the display only during vertical blanking so no frame tears.
- Tracks the move count and detects arrival at the goal cell.
- Sits between the button debouncers, the maze wall memory and the display block.

Parameters:
- GRID_BITS, 4, bits per coordinate; grid is 2^GRID_BITS square; `player_pos` = {row, col}.
- START_POS, 8'h00, position after reset or restart.
- GOAL_POS, 8'hFF, winning cell.
- COUNT_W, 16, width of `move_count`.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_up  in  1  debounced level, asynchronous to clk.
- btn_down  in  1  debounced level, asynchronous to clk.
- btn_left  in  1  debounced level, asynchronous to clk.
- btn_right  in  1  debounced level, asynchronous to clk.
- btn_restart  in  1  debounced level, asynchronous to clk.
- vblank  in  1  high while the display is in vertical blanking.
- maze_rd  out  1  one-cycle read strobe to the wall memory.
- maze_addr  out  2*GRID_BITS  cell address being read.
- maze_wall  in  1  1 = cell is wall; valid the cycle after `maze_rd`.
- player_pos  out  2*GRID_BITS  current player cell, to display.
- move_count  out  COUNT_W  committed moves, saturating.
- bump  out  1  one-cycle pulse when a move is rejected.
- game_won  out  1  high while in WON.

Behaviour:
- Reset (`reset`=0, async), all outputs and state:
  - `player_pos`=START_POS, `move_count`=0.
  - `maze_rd`=0, `maze_addr`=0, `bump`=0, `game_won`=0.
  - state=IDLE, synchronizers cleared.
- Inputs: each button uses a 2-flop synchronizer plus a rising-edge detector. Cycle E is the cycle the registered edge pulse is high.
- Simultaneous direction edges: priority up > down > left > right; the others are dropped.
- Direction edges arriving outside IDLE are dropped, not queued.
- Target computation, with row = `player_pos[7:4]` and col = `player_pos[3:0]` (generally GRID_BITS wide):
  - up: row-1.
  - down: row+1.
  - left: col-1.
  - right: col+1.
  - No wrap-around. A move off the grid (row 0 up, max row down, col 0 left, max col right) is blocked with no memory read: `bump` pulses at E+1, state stays IDLE.
- States:
  - IDLE: on a valid edge in cycle E, latch target and go to LOOKUP (entered at E+1).
  - LOOKUP (E+1): `maze_rd`=1, `maze_addr`=target; go to WAIT.
  - WAIT (E+2): sample `maze_wall`. If 1, `bump`=1 and go to IDLE; if 0, go to PEND.
  - PEND (E+3 onward): hold until `vblank`=1. In that cycle, at the next edge, `player_pos`<=target and `move_count`<=`move_count`+1 (saturating at all-ones). Then go to WON if target==GOAL_POS, else IDLE. If `vblank` is already high at E+3, the new `player_pos` is visible from E+4.
  - WON: `game_won`=1; direction edges ignored.
- Restart (`btn_restart` edge) applies in any state and has priority over everything:
  - Next cycle: `player_pos`=START_POS, `move_count`=0, `game_won`=0, state IDLE.
  - Aborts LOOKUP, WAIT or PEND; any pending target is discarded.
- `player_pos` changes only in a PEND commit cycle, or on restart/reset.
- `maze_rd` is never high outside LOOKUP and is high for exactly one cycle per lookup.
- Async reset mid-operation returns to the reset values immediately, independent of clk.
- START_POS equal to GOAL_POS is not a legal configuration.

Decomposition:
- Shared package `maze_pkg`:
  - State encoding: IDLE, LOOKUP, WAIT, PEND, WON.
  - Direction codes: DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - GRID_BITS default and position field-extraction constants.
- Sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge pulse, with the same async active-low reset. Instantiated once per button (5 instances).

Test Plan:
- Reset values: hold `reset`=0, drive `btn_right`=1 → `player_pos`=8'h00, `move_count`=0, `maze_rd`=0, `game_won`=0; release → no move until a fresh rising edge.
- Open move: pos 8'h00, `btn_right` edge, `maze_wall`=0, `vblank`=1 → `maze_rd` high exactly one cycle at E+1 with `maze_addr`=8'h01; `player_pos`=8'h01 visible at E+4; `move_count`=1.
- Wall and boundary:
  - Target cell wall=1 → `bump` pulse at E+2; `player_pos` and `move_count` unchanged.
  - At pos 8'h00, `btn_left` or `btn_up` → no `maze_rd`, `bump` at E+1.
- Vblank gating and priority:
  - `vblank`=0 for 100 cycles after lookup → `player_pos` held; commits on the first `vblank`=1 cycle.
  - `btn_up` and `btn_right` edges in the same cycle at pos 8'h11 → `maze_addr`=8'h01.
- Goal: walk to 8'hFE, `btn_right` → `player_pos`=8'hFF, `game_won`=1; further direction edges produce no `maze_rd`.
- Restart and reset mid-operation:
  - `btn_restart` edge while in PEND → pending move discarded, `player_pos`=8'h00, `move_count`=0, `game_won`=0.
  - `reset` asserted mid-LOOKUP → all outputs at reset values immediately.

Source files
------------

// File: rtl/maze_move_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the maze movement controller:
//   state_t  - controller states (IDLE, LOOKUP, WAIT, PEND, WON)
//   dir_t    - direction codes (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3)
//   BTN_*    - bit index of each button in the synchronised button vector
//   GRID_BITS_DEF / ROW_* / COL_* - default grid size and position fields
// ---------------------------------------------------------------------------
package maze_pkg;

    localparam int GRID_BITS_DEF = 4;
    localparam int POS_W_DEF     = 2 * GRID_BITS_DEF;

    // player_pos = {row, col}
    localparam int COL_LSB = 0;
    localparam int COL_MSB = GRID_BITS_DEF - 1;
    localparam int ROW_LSB = GRID_BITS_DEF;
    localparam int ROW_MSB = POS_W_DEF - 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WAIT   = 3'd2,
        PEND   = 3'd3,
        WON    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Direction buttons occupy the low bits in priority order (up highest).
    localparam int BTN_UP      = 0;
    localparam int BTN_DOWN    = 1;
    localparam int BTN_LEFT    = 2;
    localparam int BTN_RIGHT   = 3;
    localparam int BTN_RESTART = 4;
    localparam int NUM_BTN     = 5;

endpackage

// File: rtl/maze_move_ctrl_if.sv
// ---------------------------------------------------------------------------
// maze_move_ctrl_if
// Bundles the controller's buttons, display and wall-memory signals.
//   slave  : the controller (buttons/vblank/maze_wall in; memory read,
//            player_pos, move_count, bump, game_won out)
//   master : the surrounding system driving buttons, vblank and wall data
// ---------------------------------------------------------------------------
interface maze_move_ctrl_if #(
    parameter int GRID_BITS = 4,
    parameter int COUNT_W   = 16
) ();
    logic                     btn_up;
    logic                     btn_down;
    logic                     btn_left;
    logic                     btn_right;
    logic                     btn_restart;
    logic                     vblank;
    logic                     maze_rd;
    logic [2*GRID_BITS-1:0]   maze_addr;
    logic                     maze_wall;
    logic [2*GRID_BITS-1:0]   player_pos;
    logic [COUNT_W-1:0]       move_count;
    logic                     bump;
    logic                     game_won;

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_restart,
        input  vblank, maze_wall,
        output maze_rd, maze_addr, player_pos, move_count, bump, game_won
    );

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_restart,
        output vblank, maze_wall,
        input  maze_rd, maze_addr, player_pos, move_count, bump, game_won
    );
endinterface

// File: rtl/maze_move_ctrl_btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Two-flop synchroniser for an asynchronous button level followed by a
// registered rising-edge pulse (one clk cycle wide).
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   i_btn  : debounced button level, asynchronous to clk
//   o_edge : one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_edge
);
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_edge;
    // Warm-up shift: the synchroniser and history flop come out of reset
    // holding 0, which would fake a rising edge for a button already held
    // down. Edges are only trusted once r_prev holds a real sample.
    logic [2:0] r_arm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
            r_arm   <= 3'b000;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_arm   <= {r_arm[1:0], 1'b1};
            r_edge  <= r_arm[2] & r_sync2 & ~r_prev;
        end
    end

    assign o_edge = r_edge;
endmodule

// File: rtl/maze_move_ctrl.sv
// ---------------------------------------------------------------------------
// maze_move_ctrl
// Turns button edges into validated player moves: checks grid bounds, reads
// the target cell from the wall memory, and commits the new position only
// while the display is in vertical blanking. Counts moves and flags the win.
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : maze_move_ctrl_if.slave
//            in : btn_up/down/left/right/restart, vblank, maze_wall
//            out: maze_rd, maze_addr, player_pos, move_count, bump, game_won
// ---------------------------------------------------------------------------
module maze_move_ctrl
    import maze_pkg::*;
#(
    parameter int                     GRID_BITS = GRID_BITS_DEF,
    parameter logic [2*GRID_BITS-1:0] START_POS = '0,
    parameter logic [2*GRID_BITS-1:0] GOAL_POS  = '1,
    parameter int                     COUNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    maze_move_ctrl_if.slave  bus
);
    localparam int                   POS_W     = 2 * GRID_BITS;
    localparam logic [GRID_BITS-1:0] COORD_MAX = '1;

    // ---------------- button synchronisers ----------------
    logic [NUM_BTN-1:0] w_btn_level;
    logic [NUM_BTN-1:0] w_btn_edge;

    assign w_btn_level[BTN_UP]      = bus.btn_up;
    assign w_btn_level[BTN_DOWN]    = bus.btn_down;
    assign w_btn_level[BTN_LEFT]    = bus.btn_left;
    assign w_btn_level[BTN_RIGHT]   = bus.btn_right;
    assign w_btn_level[BTN_RESTART] = bus.btn_restart;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_sync_edge u_sync (
                .clk    (clk),
                .reset  (reset),
                .i_btn  (w_btn_level[gi]),
                .o_edge (w_btn_edge[gi])
            );
        end
    endgenerate

    logic w_restart;
    logic w_dir_any;
    assign w_restart = w_btn_edge[BTN_RESTART];
    assign w_dir_any = |w_btn_edge[BTN_RIGHT:BTN_UP];

    // ---------------- state ----------------
    state_t             r_state, w_state_next;
    logic [POS_W-1:0]   r_pos, w_pos_next;
    logic [POS_W-1:0]   r_target, w_target_next;
    logic [COUNT_W-1:0] r_count, w_count_next;
    logic               r_bump, w_bump_next;  // boundary rejection, shows at E+1

    // ---------------- direction decode and target ----------------
    dir_t                 w_dir;
    logic [GRID_BITS-1:0] w_row, w_col;
    logic [GRID_BITS-1:0] w_cand_row, w_cand_col;
    logic                 w_blocked;
    logic [POS_W-1:0]     w_cand;

    assign w_row  = r_pos[POS_W-1:GRID_BITS];
    assign w_col  = r_pos[GRID_BITS-1:0];
    assign w_cand = {w_cand_row, w_cand_col};

    always_comb begin
        w_dir = DIR_RIGHT;
        if (w_btn_edge[BTN_UP])        w_dir = DIR_UP;
        else if (w_btn_edge[BTN_DOWN]) w_dir = DIR_DOWN;
        else if (w_btn_edge[BTN_LEFT]) w_dir = DIR_LEFT;
    end

    // No wrap-around: stepping off the grid is flagged instead of computed.
    always_comb begin
        w_cand_row = w_row;
        w_cand_col = w_col;
        w_blocked  = 1'b0;
        case (w_dir)
            DIR_UP:    if (w_row == '0)        w_blocked = 1'b1;
                       else                    w_cand_row = w_row - 1'b1;
            DIR_DOWN:  if (w_row == COORD_MAX) w_blocked = 1'b1;
                       else                    w_cand_row = w_row + 1'b1;
            DIR_LEFT:  if (w_col == '0)        w_blocked = 1'b1;
                       else                    w_cand_col = w_col - 1'b1;
            default:   if (w_col == COORD_MAX) w_blocked = 1'b1;
                       else                    w_cand_col = w_col + 1'b1;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_pos    <= START_POS;
            r_target <= '0;
            r_count  <= '0;
            r_bump   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pos    <= w_pos_next;
            r_target <= w_target_next;
            r_count  <= w_count_next;
            r_bump   <= w_bump_next;
        end
    end

    logic                w_maze_rd;
    logic [POS_W-1:0]    w_maze_addr;
    logic                w_bump;
    logic                w_game_won;

    always_comb begin
        w_state_next  = r_state;
        w_pos_next    = r_pos;
        w_target_next = r_target;
        w_count_next  = r_count;
        w_bump_next   = 1'b0;
        w_maze_rd     = 1'b0;
        w_maze_addr   = '0;
        w_bump        = r_bump;
        w_game_won    = 1'b0;

        // State-decoded outputs. A lookup already in LOOKUP still issues its
        // read when restart lands; only its result is thrown away.
        case (r_state)
            LOOKUP: begin
                w_maze_rd   = 1'b1;
                w_maze_addr = r_target;
            end
            WAIT:    if (bus.maze_wall) w_bump = 1'b1;
            WON:     w_game_won = 1'b1;
            default: ;
        endcase

        if (w_restart) begin
            // Restart overrides everything, including a rejection pulse.
            w_state_next = IDLE;
            w_pos_next   = START_POS;
            w_count_next = '0;
            w_bump       = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dir_any) begin
                        if (w_blocked) begin
                            w_bump_next = 1'b1;
                        end else begin
                            w_target_next = w_cand;
                            w_state_next  = LOOKUP;
                        end
                    end
                end
                LOOKUP: w_state_next = WAIT;
                WAIT:   w_state_next = bus.maze_wall ? IDLE : PEND;
                PEND: begin
                    // Commit only in blanking so the display never tears.
                    if (bus.vblank) begin
                        w_pos_next = r_target;
                        if (r_count != '1) w_count_next = r_count + 1'b1;
                        w_state_next = (r_target == GOAL_POS) ? WON : IDLE;
                    end
                end
                WON:     w_state_next = WON;
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign bus.maze_rd    = w_maze_rd;
    assign bus.maze_addr  = w_maze_addr;
    assign bus.player_pos = r_pos;
    assign bus.move_count = r_count;
    assign bus.bump       = w_bump;
    assign bus.game_won   = w_game_won;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maze_move_ctrl
// Bench for maze_move_ctrl: a cycle-indexed behavioural model of the move
// rules (edge cycle E, lookup at E+1, wall result at E+2, commit on the first
// blanking cycle from E+3) checked every cycle, plus hand-computed literal
// expectations scheduled for specific cycles.
// ---------------------------------------------------------------------------
module tb_maze_move_ctrl;
    localparam int GB = 4;
    localparam int CW = 16;
    localparam int START = 8'h00;
    localparam int GOAL  = 8'hFF;

    localparam int F_POS = 0, F_CNT = 1, F_RD = 2, F_ADDR = 3, F_BUMP = 4, F_WON = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    maze_move_ctrl_if #(.GRID_BITS(GB), .COUNT_W(CW)) bus ();

    maze_move_ctrl #(
        .GRID_BITS (GB),
        .START_POS (8'h00),
        .GOAL_POS  (8'hFF),
        .COUNT_W   (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit wall_mem [256];

    // Literal expectations: checked by the compare process at cycle lit_c.
    int lit_c [256];
    int lit_f [256];
    int lit_v [256];
    int lit_n = 0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic string fname(int f);
        case (f)
            F_POS:  return "player_pos";
            F_CNT:  return "move_count";
            F_RD:   return "maze_rd";
            F_ADDR: return "maze_addr";
            F_BUMP: return "bump";
            default: return "game_won";
        endcase
    endfunction

    function automatic int dut_field(int f);
        case (f)
            F_POS:  return int'(bus.player_pos);
            F_CNT:  return int'(bus.move_count);
            F_RD:   return int'(bus.maze_rd);
            F_ADDR: return int'(bus.maze_addr);
            F_BUMP: return int'(bus.bump);
            default: return int'(bus.game_won);
        endcase
    endfunction

    task automatic chk(string nm, int n, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n, act, exp);
        end
    endtask

    // ---------------- wall memory: data valid the cycle after maze_rd -------
    initial begin
        bit rd;
        int a;
        bus.maze_wall = 1'b0;
        forever begin
            @(negedge clk);
            rd = bus.maze_rd;
            a  = int'(bus.maze_addr);
            @(posedge clk);
            #1;
            bus.maze_wall = rd ? wall_mem[a] : 1'($urandom);
        end
    end

    // ---------------- behavioural model + compare ----------------
    bit lvl [5][8];
    int m_pos, m_cnt, m_te, m_tgt, m_bump_at, m_rel;
    bit m_won, m_busy, m_in_reset;

    initial begin
        int n, r, c, tr, tc;
        bit ed [5];
        bit rs, blk;
        int exp_rd, exp_addr, exp_bump;
        m_in_reset = 1'b1;
        m_pos = START; m_cnt = 0; m_won = 0; m_busy = 0;
        m_te = -10; m_tgt = 0; m_bump_at = -1; m_rel = 0;
        forever begin
            @(negedge clk);
            n = cyc;
            lvl[0][n % 8] = bus.btn_up;
            lvl[1][n % 8] = bus.btn_down;
            lvl[2][n % 8] = bus.btn_left;
            lvl[3][n % 8] = bus.btn_right;
            lvl[4][n % 8] = bus.btn_restart;
            if (!reset) begin
                m_in_reset = 1'b1;
                m_pos = START; m_cnt = 0; m_won = 0; m_busy = 0; m_bump_at = -1;
                chk("rst player_pos", n, dut_field(F_POS), START);
                chk("rst move_count", n, dut_field(F_CNT), 0);
                chk("rst maze_rd",    n, dut_field(F_RD), 0);
                chk("rst maze_addr",  n, dut_field(F_ADDR), 0);
                chk("rst bump",       n, dut_field(F_BUMP), 0);
                chk("rst game_won",   n, dut_field(F_WON), 0);
            end else begin
                if (m_in_reset) begin
                    m_rel = n;
                    m_in_reset = 1'b0;
                end
                // Edge seen in cycle n when the level sampled three cycles
                // earlier is high and the one before it was low.
                for (int b = 0; b < 5; b++)
                    ed[b] = (n >= m_rel + 4) && lvl[b][(n - 3) % 8] && !lvl[b][(n - 4) % 8];
                rs = ed[4];

                exp_rd   = (m_busy && n == m_te + 1) ? 1 : 0;
                exp_addr = exp_rd ? m_tgt : 0;
                exp_bump = (!rs && (m_bump_at == n ||
                            (m_busy && n == m_te + 2 && bus.maze_wall))) ? 1 : 0;
                chk("player_pos", n, dut_field(F_POS), m_pos);
                chk("move_count", n, dut_field(F_CNT), m_cnt);
                chk("maze_rd",    n, dut_field(F_RD), exp_rd);
                chk("maze_addr",  n, dut_field(F_ADDR), exp_addr);
                chk("bump",       n, dut_field(F_BUMP), exp_bump);
                chk("game_won",   n, dut_field(F_WON), int'(m_won));

                if (rs) begin
                    m_pos = START; m_cnt = 0; m_won = 0; m_busy = 0; m_bump_at = -1;
                end else if (m_busy) begin
                    if (n == m_te + 2 && bus.maze_wall) begin
                        m_busy = 0;
                    end else if (n >= m_te + 3 && bus.vblank) begin
                        m_pos = m_tgt;
                        if (m_cnt < 65535) m_cnt = m_cnt + 1;
                        m_won = (m_tgt == GOAL);
                        m_busy = 0;
                    end
                end else if (!m_won && (ed[0] || ed[1] || ed[2] || ed[3])) begin
                    r = m_pos / 16; c = m_pos % 16;
                    tr = r; tc = c; blk = 0;
                    if (ed[0])      begin if (r == 0)  blk = 1; else tr = r - 1; end
                    else if (ed[1]) begin if (r == 15) blk = 1; else tr = r + 1; end
                    else if (ed[2]) begin if (c == 0)  blk = 1; else tc = c - 1; end
                    else            begin if (c == 15) blk = 1; else tc = c + 1; end
                    if (blk) m_bump_at = n + 1;
                    else begin
                        m_busy = 1; m_te = n; m_tgt = tr * 16 + tc;
                    end
                end
            end
            for (int i = 0; i < lit_n; i++)
                if (lit_c[i] == n)
                    chk({"lit ", fname(lit_f[i])}, n, dut_field(lit_f[i]), lit_v[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(int c, int f, int v);
        if (lit_n < 256) begin
            lit_c[lit_n] = c; lit_f[lit_n] = f; lit_v[lit_n] = v;
            lit_n++;
        end
    endtask

    // bit0 up, bit1 down, bit2 left, bit3 right, bit4 restart
    task automatic set_btns(bit [4:0] v);
        bus.btn_up      = v[0];
        bus.btn_down    = v[1];
        bus.btn_left    = v[2];
        bus.btn_right   = v[3];
        bus.btn_restart = v[4];
    endtask

    // One-cycle press; e returns the cycle its edge pulse is high.
    task automatic press(bit [4:0] v, output int e);
        step();
        set_btns(v);
        e = cyc + 3;
        step();
        set_btns(5'b0);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) step();
    endtask

    task automatic move(bit [4:0] v, int exp_pos);
        int e;
        press(v, e);
        expect_at(e + 4, F_POS, exp_pos);
        wait_until(e + 6);
    endtask

    localparam bit [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LT = 5'b00100,
                         B_RT = 5'b01000, B_RS = 5'b10000;

    // ---------------- main sequence ----------------
    initial begin
        int e, r, p0;
        bit [3:0] dl;
        for (int k = 0; k < 256; k++) wall_mem[k] = 1'b0;
        set_btns(B_RT);
        bus.vblank = 1'b1;

        // reset held with a button already down
        repeat (3) step();
        expect_at(cyc, F_POS, 8'h00);
        expect_at(cyc, F_CNT, 0);
        expect_at(cyc, F_RD, 0);
        expect_at(cyc, F_WON, 0);
        step();
        reset = 1'b1;
        p0 = cyc;
        for (int i = 1; i < 10; i++) expect_at(p0 + i, F_RD, 0);
        expect_at(p0 + 9, F_POS, 8'h00);
        wait_until(p0 + 10);
        set_btns(5'b0);
        repeat (3) step();

        // open move right
        press(B_RT, e);
        expect_at(e,     F_RD, 0);
        expect_at(e + 1, F_RD, 1);
        expect_at(e + 1, F_ADDR, 8'h01);
        expect_at(e + 2, F_RD, 0);
        expect_at(e + 3, F_POS, 8'h00);
        expect_at(e + 4, F_POS, 8'h01);
        expect_at(e + 4, F_CNT, 1);
        wait_until(e + 6);

        // wall at target 02
        wall_mem[2] = 1'b1;
        press(B_RT, e);
        expect_at(e + 1, F_ADDR, 8'h02);
        expect_at(e + 1, F_BUMP, 0);
        expect_at(e + 2, F_BUMP, 1);
        expect_at(e + 3, F_BUMP, 0);
        expect_at(e + 5, F_POS, 8'h01);
        expect_at(e + 5, F_CNT, 1);
        wait_until(e + 6);
        wall_mem[2] = 1'b0;

        // back to 00, then both boundaries there
        move(B_LT, 8'h00);
        press(B_UP, e);
        expect_at(e + 1, F_RD, 0);
        expect_at(e + 1, F_BUMP, 1);
        expect_at(e + 2, F_BUMP, 0);
        wait_until(e + 4);
        press(B_LT, e);
        expect_at(e + 1, F_RD, 0);
        expect_at(e + 1, F_BUMP, 1);
        expect_at(e + 3, F_POS, 8'h00);
        wait_until(e + 4);

        // blanking gate: 100 cycles without vblank
        bus.vblank = 1'b0;
        press(B_DN, e);
        expect_at(e + 1, F_ADDR, 8'h10);
        expect_at(e + 50, F_POS, 8'h00);
        expect_at(e + 103, F_POS, 8'h00);
        expect_at(e + 104, F_POS, 8'h10);
        expect_at(e + 104, F_CNT, 3);
        wait_until(e + 103);
        bus.vblank = 1'b1;
        wait_until(e + 106);

        // priority: up beats right at 11
        move(B_RT, 8'h11);
        press(B_UP | B_RT, e);
        expect_at(e + 1, F_RD, 1);
        expect_at(e + 1, F_ADDR, 8'h01);
        expect_at(e + 4, F_POS, 8'h01);
        expect_at(e + 4, F_CNT, 5);
        wait_until(e + 6);

        // restart while a move is pending
        bus.vblank = 1'b0;
        press(B_DN, e);
        wait_until(e + 5);
        press(B_RS, r);
        expect_at(r, F_POS, 8'h01);
        expect_at(r, F_CNT, 5);
        expect_at(r + 1, F_POS, 8'h00);
        expect_at(r + 1, F_CNT, 0);
        expect_at(r + 8, F_POS, 8'h00);
        wait_until(r + 2);
        bus.vblank = 1'b1;
        wait_until(r + 9);

        // walk to the goal
        for (int i = 0; i < 15; i++) move(B_DN, (i + 1) * 16);
        for (int j = 0; j < 14; j++) move(B_RT, 8'hF0 + j + 1);
        press(B_RT, e);
        expect_at(e + 3, F_WON, 0);
        expect_at(e + 4, F_POS, 8'hFF);
        expect_at(e + 4, F_WON, 1);
        expect_at(e + 4, F_CNT, 30);
        wait_until(e + 6);
        press(B_LT, e);
        expect_at(e + 1, F_RD, 0);
        expect_at(e + 1, F_BUMP, 0);
        expect_at(e + 4, F_POS, 8'hFF);
        wait_until(e + 5);
        press(B_RS, r);
        expect_at(r, F_WON, 1);
        expect_at(r + 1, F_WON, 0);
        expect_at(r + 1, F_POS, 8'h00);
        expect_at(r + 1, F_CNT, 0);
        wait_until(r + 3);

        // async reset in the middle of a lookup
        move(B_RT, 8'h01);
        press(B_DN, e);
        wait_until(e + 1);
        reset = 1'b0;
        expect_at(e + 1, F_RD, 0);
        expect_at(e + 1, F_POS, 8'h00);
        expect_at(e + 1, F_CNT, 0);
        step();
        step();
        reset = 1'b1;
        repeat (6) step();

        // randomized walk
        for (int k = 0; k < 256; k++) wall_mem[k] = ($urandom_range(0, 3) == 0);
        wall_mem[0] = 1'b0;
        dl = 4'b0;
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 4) == 0) dl[b] = ~dl[b];
            set_btns({($urandom_range(0, 149) == 0), dl});
            bus.vblank = ($urandom_range(0, 1) == 1);
            step();
        end
        set_btns(5'b0);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
